// File: rtl/traffic_phase_encoder.sv
// traffic_phase_encoder
//   Walks the fixed five-phase intersection cycle P0..P4 and drives the 8-bit
//   A..H light code for the downstream decoder. Phase timing is counted in
//   seconds derived from CLK. The Lane 1/2 green (P1) is extended one second
//   at a time while no Lane 4 vehicle is sensed, up to MAX_EXT seconds.
//   HOLD freezes all timing.
//
// Ports
//   CLK        in   system clock
//   rst_n      in   asynchronous active-low reset
//   SENSE4     in   Lane 4 vehicle present (asynchronous, synchronized here)
//   HOLD       in   freeze prescaler, timers and phase while high
//   CODE[7:0]  out  registered phase code, CODE[7]=A .. CODE[0]=H
//   PHASE[2:0] out  registered phase index 0..4
//   PHASE_STB  out  one-cycle pulse on the cycle CODE takes a new value
//   TICK       out  one-cycle pulse at each one-second boundary
module traffic_phase_encoder #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned T_P0          = 20,
  parameter int unsigned T_P1          = 10,
  parameter int unsigned T_P2          = 3,
  parameter int unsigned T_P3          = 15,
  parameter int unsigned T_P4          = 3,
  parameter int unsigned MAX_EXT       = 30
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       SENSE4,
  input  logic       HOLD,
  output logic [7:0] CODE,
  output logic [2:0] PHASE,
  output logic       PHASE_STB,
  output logic       TICK
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  // A zero duration would never expire; treat it as one second.
  localparam logic [7:0] DUR0 = (T_P0 == 0) ? 8'd1 : 8'(T_P0);
  localparam logic [7:0] DUR1 = (T_P1 == 0) ? 8'd1 : 8'(T_P1);
  localparam logic [7:0] DUR2 = (T_P2 == 0) ? 8'd1 : 8'(T_P2);
  localparam logic [7:0] DUR3 = (T_P3 == 0) ? 8'd1 : 8'(T_P3);
  localparam logic [7:0] DUR4 = (T_P4 == 0) ? 8'd1 : 8'(T_P4);
  localparam logic [7:0] EXT_LIMIT = 8'(MAX_EXT);

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4
  } phase_e;

  function automatic logic [7:0] code_of(input phase_e p);
    case (p)
      PH0:     code_of = 8'b0100_0111;
      PH1:     code_of = 8'b0101_1111;
      PH2:     code_of = 8'b1000_1011;
      PH3:     code_of = 8'b1100_1101;
      PH4:     code_of = 8'b1100_1110;
      default: code_of = 8'b0100_0111;
    endcase
  endfunction

  logic             s4_meta_q, s4_q;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]       sec_cnt_q, sec_cnt_d;
  logic [7:0]       ext_cnt_q, ext_cnt_d;
  phase_e           phase_q, phase_d;
  logic [7:0]       code_q, code_d;
  logic             stb_q, stb_d;
  logic             tick;
  logic             expire;
  logic [7:0]       t_cur;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      s4_meta_q <= 1'b0;
      s4_q      <= 1'b0;
      pre_cnt_q <= '0;
      sec_cnt_q <= 8'd0;
      ext_cnt_q <= 8'd0;
      phase_q   <= PH0;
      code_q    <= 8'b0100_0111;
      stb_q     <= 1'b0;
    end else begin
      s4_meta_q <= SENSE4;
      s4_q      <= s4_meta_q;
      pre_cnt_q <= pre_cnt_d;
      sec_cnt_q <= sec_cnt_d;
      ext_cnt_q <= ext_cnt_d;
      phase_q   <= phase_d;
      code_q    <= code_d;
      stb_q     <= stb_d;
    end
  end

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    sec_cnt_d = sec_cnt_q;
    ext_cnt_d = ext_cnt_q;
    phase_d   = phase_q;
    stb_d     = 1'b0;

    case (phase_q)
      PH0:     t_cur = DUR0;
      PH1:     t_cur = DUR1;
      PH2:     t_cur = DUR2;
      PH3:     t_cur = DUR3;
      PH4:     t_cur = DUR4;
      default: t_cur = DUR0;
    endcase

    // HOLD masks the tick, so every counter and the phase stay frozen.
    tick   = (pre_cnt_q == PRE_MAX) && !HOLD;
    expire = tick && (sec_cnt_q == t_cur - 8'd1);

    if (!HOLD) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    end
    if (tick) begin
      sec_cnt_d = sec_cnt_q + 8'd1;
    end

    case (phase_q)
      PH0: if (expire) begin
        phase_d   = PH1;
        sec_cnt_d = 8'd0;
        ext_cnt_d = 8'd0;
        stb_d     = 1'b1;
      end
      PH1: if (expire) begin
        if (s4_q || (ext_cnt_q == EXT_LIMIT)) begin
          phase_d   = PH2;
          sec_cnt_d = 8'd0;
          ext_cnt_d = 8'd0;
          stb_d     = 1'b1;
        end else begin
          // Extend by one second: keep sec_cnt parked at its last value so
          // the next tick re-evaluates expiry.
          ext_cnt_d = ext_cnt_q + 8'd1;
          sec_cnt_d = sec_cnt_q;
        end
      end
      PH2: if (expire) begin
        phase_d   = PH3;
        sec_cnt_d = 8'd0;
        stb_d     = 1'b1;
      end
      PH3: if (expire) begin
        phase_d   = PH4;
        sec_cnt_d = 8'd0;
        stb_d     = 1'b1;
      end
      PH4: if (expire) begin
        phase_d   = PH0;
        sec_cnt_d = 8'd0;
        stb_d     = 1'b1;
      end
      default: begin
        // Illegal encoding: recover to a clean P0 start.
        phase_d   = PH0;
        pre_cnt_d = '0;
        sec_cnt_d = 8'd0;
        ext_cnt_d = 8'd0;
        stb_d     = 1'b1;
      end
    endcase

    code_d = code_of(phase_d);
  end

  assign CODE      = code_q;
  assign PHASE     = phase_q;
  assign PHASE_STB = stb_q;
  assign TICK      = tick;

endmodule
